traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Phase controller for the single-crossing traffic signal. It sits around the timer block on both sides. It drives the timer's `TimerRef` reload value for the current phase, and it advances its state machine on the timer's one-cycle `trigger` pulse. It converts the timer's `timeRemaining` count into two BCD digits for the countdown display, and it arbitrates a latched pedestrian request.

## Interface
- `GREEN_TIME`, default 30: car green phase length, in clock ticks (1..128)
- `YELLOW_TIME`, default 5: car yellow phase length (1..128)
- `ALLRED_TIME`, default 2: all-red clearance phase length (1..128)
- `WALK_TIME`, default 20: pedestrian walk phase length (1..128)
- `CLEAR_TIME`, default 6: pedestrian clearance (flashing don't-walk) phase length (1..128)
- `clock`, input, 1: single system clock, rising edge; same clock as the timer
- `reset`, input, 1: asynchronous, active-low reset; top level drives the timer's active-high reset with `~reset`
- `trigger`, input, 1: one-cycle end-of-phase pulse from the timer
- `timeRemaining`, input, 7: timer countdown value
- `pedRequest`, input, 1: pedestrian button, already synchronised, level or pulse
- `TimerRef`, output, 7: reload value fed to the timer, equal to phase length − 1
- `carRed`, `carYellow`, `carGreen`, output, 1 each: car lamps
- `pedWalk`, `pedDontWalk`, output, 1 each: pedestrian lamps
- `pedPending`, output, 1: request-latched indicator (button lamp)
- `tensDigit`, `unitsDigit`, output, 4 each: BCD countdown display

## Operation
- States are GREEN, YELLOW, ALLRED, WALK and CLEAR. All state, outputs and `pedPending` are registered.
- Transitions occur only on a rising edge with `trigger`=1; otherwise the state holds:
  - GREEN → YELLOW
  - YELLOW → ALLRED
  - ALLRED → WALK if `pedPending`=1, else GREEN
  - WALK → CLEAR
  - CLEAR → GREEN
- `TimerRef` is loaded on the same edge as the transition, with (new phase length − 1). The phase lengths are GREEN_TIME, YELLOW_TIME, ALLRED_TIME, WALK_TIME and CLEAR_TIME. Phase length 128 gives `TimerRef`=127.
- Lamps are decoded from the registered state:
  - GREEN: carGreen, pedDontWalk
  - YELLOW: carYellow, pedDontWalk
  - ALLRED: carRed, pedDontWalk
  - WALK: carRed, pedWalk
  - CLEAR: carRed, with pedDontWalk = ~`timeRemaining`[0] (flashing)
  - Exactly one car lamp is high at all times. `pedWalk` and `pedDontWalk` are never both 1.
- `pedPending`:
  - Set on any edge with `pedRequest`=1 while in GREEN, YELLOW or ALLRED.
  - Cleared on the edge entering WALK. Clear wins over a simultaneous set.
  - Requests during WALK or CLEAR are ignored and not latched.
- Display:
  - `tensDigit` = `timeRemaining`/10 and `unitsDigit` = `timeRemaining`%10, registered.
  - Values above 99 saturate to 9,9.
  - Division is implemented as a compare/subtract chain; no divider IP.

## Timing
- Reset (`reset`=0, asynchronous) forces state GREEN, `TimerRef`=GREEN_TIME−1, carGreen=1, carYellow=0, carRed=0, pedDontWalk=1, pedWalk=0, pedPending=0, tensDigit=0, unitsDigit=0.
- The timer reloads on its own trigger edge, so each phase lasts exactly `TimerRef`+1 clocks of the timer. The controller changes `TimerRef` in the same cycle the timer restarts its count, and the new value takes effect from the next count comparison.
- State-to-lamp latency is 0 cycles, because lamps are a registered decode of state. Trigger-to-lamp change is 1 edge.
- Display latency is 1 cycle from `timeRemaining`.
- If `reset` deasserts in the same cycle that `trigger`=1, the trigger is ignored and state stays GREEN.
- A reset asserted mid-phase discards any pending request.
- `trigger` is assumed to be a single cycle. If it stays high for consecutive cycles, the controller advances once per high cycle; no filtering is applied.

## Test plan
Unless stated otherwise, scenarios use GREEN=4, YELLOW=2, ALLRED=1, WALK=3, CLEAR=2, with the timer instantiated and free-running.
- Reset, then hold `pedRequest`=0 for 40 clocks → cycle is GREEN(4)-YELLOW(2)-ALLRED(1) repeating. `TimerRef` reads 3, 1, 0. WALK is never entered.
- Pulse `pedRequest` 1 cycle during YELLOW → `pedPending`=1 until the ALLRED→WALK edge. Then WALK(3) with `pedWalk`=1, then CLEAR(2) with `pedDontWalk` toggling with `timeRemaining`[0], then GREEN. `pedPending`=0 from WALK entry onward.
- Hold `pedRequest`=1 across the ALLRED→WALK edge and through WALK → `pedPending` is 0 in WALK and CLEAR, and sets again in the cycle after GREEN entry.
- Force `timeRemaining`=0, 9, 10, 99, 100, 127 → digits (0,0), (0,9), (1,0), (9,9), (9,9), (9,9) one cycle later.
- Assert `reset`=0 mid-WALK for 1 cycle → outputs immediately take reset values. Release → GREEN with `TimerRef`=3 and `pedPending`=0.
- Every cycle of a 2000-cycle random `pedRequest` run → exactly one car lamp is high, and never `pedWalk` && `pedDontWalk`. carGreen and `pedWalk` are never high together.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Phase controller for a single-crossing signal: sequences car/ped phases, loads timer reload values, BCD countdown display.
// Latency: trigger-to-lamp/TimerRef change is one edge; timeRemaining-to-digits is one cycle.
// Backpressure: none; a trigger is honoured on every cycle it is high (except the first edge after reset release).
// Ports:
//   clock, reset (async, active-low)  | trigger, timeRemaining[6:0] from the timer | pedRequest (synchronised button)
//   TimerRef[6:0] to the timer        | carRed/carYellow/carGreen, pedWalk/pedDontWalk, pedPending lamps
//   tensDigit[3:0], unitsDigit[3:0]   | registered BCD of timeRemaining, saturating at 99
module traffic_phase_ctrl #(
  parameter int GREEN_TIME  = 30,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 20,
  parameter int CLEAR_TIME  = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [6:0] timeRemaining,
  input  logic       pedRequest,
  output logic [6:0] TimerRef,
  output logic       carRed,
  output logic       carYellow,
  output logic       carGreen,
  output logic       pedWalk,
  output logic       pedDontWalk,
  output logic       pedPending,
  output logic [3:0] tensDigit,
  output logic [3:0] unitsDigit
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_WALK   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  // Phase length 1..128 maps onto a 7-bit reload of length-1.
  localparam logic [6:0] REF_GREEN  = 7'(GREEN_TIME - 1);
  localparam logic [6:0] REF_YELLOW = 7'(YELLOW_TIME - 1);
  localparam logic [6:0] REF_ALLRED = 7'(ALLRED_TIME - 1);
  localparam logic [6:0] REF_WALK   = 7'(WALK_TIME - 1);
  localparam logic [6:0] REF_CLEAR  = 7'(CLEAR_TIME - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_run;
  logic [6:0] r_timer_ref;
  logic       r_car_red;
  logic       r_car_yellow;
  logic       r_car_green;
  logic       r_ped_walk;
  logic       r_ped_dont_walk;
  logic       r_ped_pending;
  logic [3:0] r_tens;
  logic [3:0] r_units;

  logic [6:0] w_timer_ref;
  logic       w_ped_dont_walk;
  logic       w_ped_pending;
  logic       w_enter_walk;
  logic       w_req_window;
  logic [6:0] w_rem;
  logic [3:0] w_tens;

  // Next-state: advance only on trigger. r_run is low for the first edge after
  // reset release so a trigger coincident with release is ignored.
  always_comb begin
    w_next = r_state;
    if (trigger && r_run) begin
      case (r_state)
        S_GREEN:  w_next = S_YELLOW;
        S_YELLOW: w_next = S_ALLRED;
        S_ALLRED: w_next = r_ped_pending ? S_WALK : S_GREEN;
        S_WALK:   w_next = S_CLEAR;
        S_CLEAR:  w_next = S_GREEN;
        default:  w_next = S_GREEN;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they change on the
  // same edge as the state itself. In CLEAR the don't-walk lamp follows bit 0
  // of the count as seen in the cycle before the edge.
  always_comb begin
    w_timer_ref     = REF_GREEN;
    w_ped_dont_walk = 1'b1;
    case (w_next)
      S_GREEN:  w_timer_ref = REF_GREEN;
      S_YELLOW: w_timer_ref = REF_YELLOW;
      S_ALLRED: w_timer_ref = REF_ALLRED;
      S_WALK: begin
        w_timer_ref     = REF_WALK;
        w_ped_dont_walk = 1'b0;
      end
      S_CLEAR: begin
        w_timer_ref     = REF_CLEAR;
        w_ped_dont_walk = ~timeRemaining[0];
      end
      default: w_timer_ref = REF_GREEN;
    endcase
  end

  // Request latch: clearing on WALK entry takes priority over a new request.
  assign w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);
  assign w_req_window = (r_state == S_GREEN) || (r_state == S_YELLOW) || (r_state == S_ALLRED);

  always_comb begin
    w_ped_pending = r_ped_pending;
    if (w_enter_walk) begin
      w_ped_pending = 1'b0;
    end else if (pedRequest && w_req_window) begin
      w_ped_pending = 1'b1;
    end
  end

  // Binary to two BCD digits by nine compare/subtract-10 stages.
  always_comb begin
    w_tens = 4'd0;
    w_rem  = timeRemaining;
    if (timeRemaining > 7'd99) begin
      w_tens = 4'd9;
      w_rem  = 7'd9;
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (w_rem >= 7'd10) begin
          w_rem  = w_rem - 7'd10;
          w_tens = w_tens + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_GREEN;
      r_run           <= 1'b0;
      r_timer_ref     <= REF_GREEN;
      r_car_red       <= 1'b0;
      r_car_yellow    <= 1'b0;
      r_car_green     <= 1'b1;
      r_ped_walk      <= 1'b0;
      r_ped_dont_walk <= 1'b1;
      r_ped_pending   <= 1'b0;
      r_tens          <= 4'd0;
      r_units         <= 4'd0;
    end else begin
      r_state         <= w_next;
      r_run           <= 1'b1;
      r_timer_ref     <= w_timer_ref;
      r_car_green     <= (w_next == S_GREEN);
      r_car_yellow    <= (w_next == S_YELLOW);
      r_car_red       <= (w_next != S_GREEN) && (w_next != S_YELLOW);
      r_ped_walk      <= (w_next == S_WALK);
      r_ped_dont_walk <= w_ped_dont_walk;
      r_ped_pending   <= w_ped_pending;
      r_tens          <= w_tens;
      r_units         <= w_rem[3:0];
    end
  end

  assign TimerRef    = r_timer_ref;
  assign carRed      = r_car_red;
  assign carYellow   = r_car_yellow;
  assign carGreen    = r_car_green;
  assign pedWalk     = r_ped_walk;
  assign pedDontWalk = r_ped_dont_walk;
  assign pedPending  = r_ped_pending;
  assign tensDigit   = r_tens;
  assign unitsDigit  = r_units;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with a small reloading timer model around it.
// Phases: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, CLEAR=2.
// Trigger and timeRemaining can be overridden for display and edge-case steps.
module tb_traffic_phase_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [6:0] timeRemaining;
  logic       pedRequest;
  logic [6:0] TimerRef;
  logic       carRed, carYellow, carGreen;
  logic       pedWalk, pedDontWalk, pedPending;
  logic [3:0] tensDigit, unitsDigit;

  // Lamp vector {carGreen, carYellow, carRed, pedWalk, pedDontWalk}
  localparam logic [4:0] L_G  = 5'b10001;
  localparam logic [4:0] L_Y  = 5'b01001;
  localparam logic [4:0] L_R  = 5'b00101;
  localparam logic [4:0] L_W  = 5'b00110;
  localparam logic [4:0] L_CL = 5'b00101;  // clear, don't-walk lit
  localparam logic [4:0] L_CD = 5'b00100;  // clear, don't-walk dark

  logic [4:0] lamps;
  assign lamps = {carGreen, carYellow, carRed, pedWalk, pedDontWalk};

  // Timer model: up-counter reloading to 0 on its own trigger, compared against TimerRef.
  logic [6:0] tmr_cnt;
  logic       tmr_trig;
  logic       frc_trig_en, frc_trig;
  logic       frc_rem_en;
  logic [6:0] frc_rem;

  assign tmr_trig      = (tmr_cnt == TimerRef);
  assign trigger       = frc_trig_en ? frc_trig : tmr_trig;
  assign timeRemaining = frc_rem_en ? frc_rem : (TimerRef - tmr_cnt);

  always @(posedge clock or negedge reset) begin
    if (!reset)        tmr_cnt <= 7'd0;
    else if (tmr_trig) tmr_cnt <= 7'd0;
    else               tmr_cnt <= tmr_cnt + 7'd1;
  end

  always #5 clock = ~clock;

  traffic_phase_ctrl #(
    .GREEN_TIME (4),
    .YELLOW_TIME(2),
    .ALLRED_TIME(1),
    .WALK_TIME  (3),
    .CLEAR_TIME (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger      (trigger),
    .timeRemaining(timeRemaining),
    .pedRequest   (pedRequest),
    .TimerRef     (TimerRef),
    .carRed       (carRed),
    .carYellow    (carYellow),
    .carGreen     (carGreen),
    .pedWalk      (pedWalk),
    .pedDontWalk  (pedDontWalk),
    .pedPending   (pedPending),
    .tensDigit    (tensDigit),
    .unitsDigit   (unitsDigit)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit before checking/driving.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  logic [6:0] disp_val [8] = '{7'd0, 7'd9, 7'd10, 7'd99, 7'd100, 7'd127, 7'd45, 7'd58};
  logic [3:0] disp_ten [8] = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd9, 4'd9, 4'd4, 4'd5};
  logic [3:0] disp_one [8] = '{4'd0, 4'd9, 4'd0, 4'd9, 4'd9, 4'd9, 4'd5, 4'd8};

  initial begin
    logic [4:0] exp_l;
    logic [6:0] exp_r;
    int         walk_cycles;
    logic       ok;

    reset = 1'b0; pedRequest = 1'b0;
    frc_trig_en = 1'b0; frc_trig = 1'b0; frc_rem_en = 1'b0; frc_rem = 7'd0;

    // Reset state
    step(3);
    chk("rst_lamps", lamps, L_G);
    chk("rst_ref", TimerRef, 3);
    chk("rst_pending", pedPending, 0);
    chk("rst_tens", tensDigit, 0);
    chk("rst_units", unitsDigit, 0);

    // No requests: G(4) Y(2) R(1) repeating, never WALK
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ((i % 7) < 4)      begin exp_l = L_G; exp_r = 7'd3; end
      else if ((i % 7) < 6) begin exp_l = L_Y; exp_r = 7'd1; end
      else                  begin exp_l = L_R; exp_r = 7'd0; end
      chk("cycle_lamps", lamps, exp_l);
      chk("cycle_ref", TimerRef, exp_r);
      step(1);
    end

    // Cycle 40 is the second YELLOW cycle: one-cycle request pulse
    pedRequest = 1'b1;
    chk("req_y_lamps", lamps, L_Y);
    chk("req_y_pend_before", pedPending, 0);
    step(1); pedRequest = 1'b0;
    chk("req_ar_lamps", lamps, L_R);
    chk("req_ar_pend", pedPending, 1);
    chk("req_ar_ref", TimerRef, 0);
    step(1);
    chk("walk1_lamps", lamps, L_W);
    chk("walk1_pend", pedPending, 0);
    chk("walk1_ref", TimerRef, 2);
    step(1);
    chk("walk2_lamps", lamps, L_W);
    step(1);
    chk("walk3_lamps", lamps, L_W);
    step(1);
    chk("clear1_lamps", lamps, L_CL);
    chk("clear1_ref", TimerRef, 1);
    step(1);
    chk("clear2_lamps", lamps, L_CD);
    chk("clear2_pend", pedPending, 0);
    step(1);
    chk("green_after_walk", lamps, L_G);
    chk("green_after_walk_ref", TimerRef, 3);

    // Held request across ALLRED->WALK and through WALK/CLEAR
    step(5);
    pedRequest = 1'b1;
    chk("hold_y_lamps", lamps, L_Y);
    step(1);
    chk("hold_ar_pend", pedPending, 1);
    step(1);
    chk("hold_walk_lamps", lamps, L_W);
    chk("hold_walk_pend", pedPending, 0);
    step(2);
    chk("hold_walk3_pend", pedPending, 0);
    step(1);
    chk("hold_clear_lamps", lamps, L_CL);
    chk("hold_clear_pend", pedPending, 0);
    step(1);
    chk("hold_clear2_pend", pedPending, 0);
    step(1);
    chk("hold_green_lamps", lamps, L_G);
    chk("hold_green_pend", pedPending, 0);
    step(1);
    chk("hold_green2_pend", pedPending, 1);
    pedRequest = 1'b0;

    // Pending request carries into the next WALK; reset lands mid-WALK
    step(6);
    chk("second_walk_lamps", lamps, L_W);
    step(1);
    reset = 1'b0;
    #1;
    chk("midwalk_rst_lamps", lamps, L_G);
    chk("midwalk_rst_ref", TimerRef, 3);
    chk("midwalk_rst_pend", pedPending, 0);
    chk("midwalk_rst_tens", tensDigit, 0);
    step(1); reset = 1'b1;
    step(1);
    chk("post_rst_lamps", lamps, L_G);
    chk("post_rst_ref", TimerRef, 3);
    chk("post_rst_pend", pedPending, 0);

    // Reset discards a latched request
    pedRequest = 1'b1;
    step(1); pedRequest = 1'b0;
    chk("latch_before_rst", pedPending, 1);
    reset = 1'b0;
    #1;
    chk("latch_rst_clear", pedPending, 0);
    step(1); reset = 1'b1;
    step(1);
    chk("latch_after_rst", pedPending, 0);
    step(6);
    chk("no_walk_after_rst", lamps, L_G);
    chk("no_walk_after_rst_ref", TimerRef, 3);

    // Display conversion with forced count
    frc_rem_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frc_rem = disp_val[i];
      step(1);
      chk("disp_tens", tensDigit, disp_ten[i]);
      chk("disp_units", unitsDigit, disp_one[i]);
    end
    frc_rem = 7'd37;
    #1;
    chk("disp_latency_tens", tensDigit, 5);
    chk("disp_latency_units", unitsDigit, 8);
    step(1);
    chk("disp_37_tens", tensDigit, 3);
    chk("disp_37_units", unitsDigit, 7);
    frc_rem_en = 1'b0;

    // Trigger high at reset release is ignored; held trigger advances each cycle
    reset = 1'b0; frc_trig_en = 1'b1; frc_trig = 1'b1;
    step(1); reset = 1'b1;
    step(1);
    chk("rel_trig_lamps", lamps, L_G);
    chk("rel_trig_ref", TimerRef, 3);
    step(1);
    chk("cont_trig_y", lamps, L_Y);
    chk("cont_trig_y_ref", TimerRef, 1);
    step(1);
    chk("cont_trig_r", lamps, L_R);
    chk("cont_trig_r_ref", TimerRef, 0);
    frc_trig = 1'b0;
    step(1);
    chk("no_trig_hold", lamps, L_R);
    frc_trig = 1'b1;
    step(1);
    chk("ar_to_green", lamps, L_G);
    chk("ar_to_green_ref", TimerRef, 3);
    frc_trig_en = 1'b0; frc_trig = 1'b0;
    reset = 1'b0;
    step(1); reset = 1'b1;

    // Random requests: lamp invariants every cycle
    walk_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      pedRequest = ($urandom_range(0, 9) == 0);
      step(1);
      ok = ((carGreen + carYellow + carRed) == 1) && !(pedWalk && pedDontWalk) && !(carGreen && pedWalk);
      chk("rand_invariant", ok, 1);
      if (pedWalk) walk_cycles++;
    end
    chk("rand_walk_seen", (walk_cycles > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
